// File: rtl/multi_channel_timer.sv
// Multi-channel timer: one shared prescaler feeding CHANNELS independent tick counters,
// each with free-run, periodic or one-shot behaviour and a sticky match flag.
module multi_channel_timer #(
   parameter int CHANNELS       = 4,
   parameter int COUNTER_WIDTH  = 32,
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [PRESCALE_WIDTH-1:0]         prescale_div,
   input  logic [CHANNELS-1:0]               ch_enable,
   input  logic [CHANNELS-1:0]               ch_clear,
   input  logic [2*CHANNELS-1:0]             ch_mode,
   input  logic [CHANNELS*COUNTER_WIDTH-1:0] ch_compare,
   input  logic [CHANNELS-1:0]               flag_clear,
   output logic                              tick,
   output logic [CHANNELS*COUNTER_WIDTH-1:0] ch_count,
   output logic [CHANNELS-1:0]               match_flag,
   output logic                              irq
);

   typedef enum logic [1:0] {
      MODE_FREE_RUN = 2'b00,
      MODE_PERIODIC = 2'b01,
      MODE_ONE_SHOT = 2'b10,
      MODE_RESERVED = 2'b11
   } mode_e;

   logic [PRESCALE_WIDTH-1:0] pre;
   logic                      any_enable;
   logic                      pre_expired;

   // Using >= rather than == lets a lowered divider take effect immediately without wrapping.
   assign any_enable  = |ch_enable;
   assign pre_expired = (pre >= prescale_div);
   assign tick        = any_enable && pre_expired;

   always_ff @(posedge clock) begin
      if (reset) begin
         pre <= '0;
      end else if (!any_enable || pre_expired) begin
         pre <= '0;
      end else begin
         pre <= pre + PRESCALE_WIDTH'(1);
      end
   end

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
         mode_e                    mode;
         logic [COUNTER_WIDTH-1:0] compare;
         logic [COUNTER_WIDTH-1:0] count;
         logic [COUNTER_WIDTH-1:0] count_next;
         logic                     done;
         logic                     done_next;
         logic                     flag;
         logic                     hit;
         logic                     advance;
         logic                     set_flag;

         assign mode    = mode_e'(ch_mode[2*i +: 2]);
         assign compare = ch_compare[i*COUNTER_WIDTH +: COUNTER_WIDTH];
         assign hit     = (count == compare);
         // A clear outranks the tick, so a coincident match neither moves the count nor raises the flag.
         assign advance = tick && ch_enable[i] && !done && !ch_clear[i];

         always_comb begin
            count_next = count;
            done_next  = done;
            set_flag   = 1'b0;
            if (advance) begin
               set_flag = hit;
               case (mode)
                  MODE_PERIODIC: begin
                     count_next = hit ? '0 : count + COUNTER_WIDTH'(1);
                  end
                  MODE_ONE_SHOT: begin
                     if (hit) begin
                        done_next = 1'b1;
                     end else begin
                        count_next = count + COUNTER_WIDTH'(1);
                     end
                  end
                  default: begin
                     count_next = count + COUNTER_WIDTH'(1);
                  end
               endcase
            end
            if (ch_clear[i]) begin
               count_next = '0;
               done_next  = 1'b0;
            end
         end

         // Setting the flag beats flag_clear on the same edge so no match event is lost.
         always_ff @(posedge clock) begin
            if (reset) begin
               count <= '0;
               done  <= 1'b0;
               flag  <= 1'b0;
            end else begin
               count <= count_next;
               done  <= done_next;
               if (set_flag) begin
                  flag <= 1'b1;
               end else if (flag_clear[i]) begin
                  flag <= 1'b0;
               end
            end
         end

         assign ch_count[i*COUNTER_WIDTH +: COUNTER_WIDTH] = count;
         assign match_flag[i]                              = flag;
      end
   endgenerate

   assign irq = |match_flag;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Self-checking bench for multi_channel_timer: directed scenarios plus randomized traffic
// compared against a behavioural model of the timer rules.
module tb_multi_channel_timer;

   localparam int CH = 4;
   localparam int CW = 4;
   localparam int PW = 8;
   localparam int MW = 2 * CH;
   localparam int VW = CH * CW;

   logic          clock;
   logic          reset;
   logic [PW-1:0] prescale_div;
   logic [CH-1:0] ch_enable;
   logic [CH-1:0] ch_clear;
   logic [MW-1:0] ch_mode;
   logic [VW-1:0] ch_compare;
   logic [CH-1:0] flag_clear;
   logic          tick;
   logic [VW-1:0] ch_count;
   logic [CH-1:0] match_flag;
   logic          irq;

   int total;
   int bad;

   int m_pre;
   int m_count [CH];
   bit m_done  [CH];
   bit m_flag  [CH];

   multi_channel_timer #(
      .CHANNELS       (CH),
      .COUNTER_WIDTH  (CW),
      .PRESCALE_WIDTH (PW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .prescale_div (prescale_div),
      .ch_enable    (ch_enable),
      .ch_clear     (ch_clear),
      .ch_mode      (ch_mode),
      .ch_compare   (ch_compare),
      .flag_clear   (flag_clear),
      .tick         (tick),
      .ch_count     (ch_count),
      .match_flag   (match_flag),
      .irq          (irq)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic bit m_tick();
      return (ch_enable != '0) && (m_pre >= int'(prescale_div));
   endfunction

   function automatic int dut_count(input int ch);
      return int'(ch_count[ch*CW +: CW]);
   endfunction

   function automatic bit m_irq();
      bit any;
      any = 1'b0;
      for (int c = 0; c < CH; c++) any = any | m_flag[c];
      return any;
   endfunction

   // Reference behaviour: one call per clock edge, using the inputs present before the edge.
   task automatic model_advance();
      bit t;
      bit hit;
      int mode;
      int cmp;
      t = m_tick();
      if (reset) begin
         m_pre = 0;
         for (int c = 0; c < CH; c++) begin
            m_count[c] = 0;
            m_done[c]  = 1'b0;
            m_flag[c]  = 1'b0;
         end
      end else begin
         m_pre = (ch_enable != '0 && m_pre < int'(prescale_div)) ? m_pre + 1 : 0;
         for (int c = 0; c < CH; c++) begin
            mode = int'(ch_mode[2*c +: 2]);
            cmp  = int'(ch_compare[c*CW +: CW]);
            hit  = 1'b0;
            if (ch_clear[c]) begin
               m_count[c] = 0;
               m_done[c]  = 1'b0;
            end else if (t && ch_enable[c] && !m_done[c]) begin
               hit = (m_count[c] == cmp);
               if (hit && mode == 1)      m_count[c] = 0;
               else if (hit && mode == 2) m_done[c]  = 1'b1;
               else                       m_count[c] = (m_count[c] + 1) % (1 << CW);
            end
            if (hit)                m_flag[c] = 1'b1;
            else if (flag_clear[c]) m_flag[c] = 1'b0;
         end
      end
   endtask

   task automatic step();
      model_advance();
      @(posedge clock);
      #1;
   endtask

   task automatic set_mode(input int ch, input logic [1:0] m);
      ch_mode[2*ch +: 2] = m;
   endtask

   task automatic set_compare(input int ch, input int v);
      ch_compare[ch*CW +: CW] = CW'(v);
   endtask

   task automatic quiesce();
      ch_enable  = '0;
      ch_clear   = '1;
      flag_clear = '1;
      step();
      ch_clear   = '0;
      flag_clear = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ch_enable = '1;
      step();
      reset = 1'b0;
      ch_enable = '0;
      #1;
      total++; if (ch_count !== '0) begin bad++; $display("[TB] FAIL reset_count: got %h expected 0", ch_count); end
      total++; if (match_flag !== '0) begin bad++; $display("[TB] FAIL reset_flag: got %b expected 0", match_flag); end
      total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
      total++; if (tick !== 1'b0) begin bad++; $display("[TB] FAIL reset_tick: got %b expected 0", tick); end
   endtask

   task automatic test_periodic();
      int exp_cnt;
      prescale_div = 4;
      set_mode(0, 2'b01);
      set_compare(0, 3);
      ch_enable = 4'b0001;
      for (int c = 1; c <= 20; c++) begin
         #1;
         total++; if (tick !== (c % 5 == 0)) begin bad++; $display("[TB] FAIL periodic_tick clk%0d: got %b expected %b", c, tick, (c % 5 == 0)); end
         step();
         if (c % 5 == 0) begin
            exp_cnt = (c == 20) ? 0 : c / 5;
            total++; if (dut_count(0) !== exp_cnt) begin bad++; $display("[TB] FAIL periodic_count clk%0d: got %0d expected %0d", c, dut_count(0), exp_cnt); end
            total++; if (match_flag[0] !== (c == 20)) begin bad++; $display("[TB] FAIL periodic_flag clk%0d: got %b expected %b", c, match_flag[0], (c == 20)); end
         end
      end
      total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL periodic_irq: got %b expected 1", irq); end
      flag_clear = 4'b0001;
      step();
      flag_clear = '0;
      total++; if (match_flag[0] !== 1'b0) begin bad++; $display("[TB] FAIL periodic_flag_clear: got %b expected 0", match_flag[0]); end
      total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL periodic_irq_clear: got %b expected 0", irq); end
      quiesce();
   endtask

   task automatic test_oneshot();
      int exp_cnt;
      prescale_div = 0;
      set_mode(1, 2'b10);
      set_compare(1, 2);
      ch_enable = 4'b0010;
      for (int k = 1; k <= 6; k++) begin
         #1;
         total++; if (tick !== 1'b1) begin bad++; $display("[TB] FAIL oneshot_tick %0d: got %b expected 1", k, tick); end
         step();
         exp_cnt = (k < 2) ? k : 2;
         total++; if (dut_count(1) !== exp_cnt) begin bad++; $display("[TB] FAIL oneshot_count %0d: got %0d expected %0d", k, dut_count(1), exp_cnt); end
         total++; if (match_flag[1] !== (k >= 3)) begin bad++; $display("[TB] FAIL oneshot_flag %0d: got %b expected %b", k, match_flag[1], (k >= 3)); end
      end
      ch_clear = 4'b0010;
      step();
      ch_clear = '0;
      total++; if (dut_count(1) !== 0) begin bad++; $display("[TB] FAIL oneshot_clear: got %0d expected 0", dut_count(1)); end
      total++; if (match_flag[1] !== 1'b1) begin bad++; $display("[TB] FAIL oneshot_clear_flag: got %b expected 1", match_flag[1]); end
      step();
      total++; if (dut_count(1) !== 1) begin bad++; $display("[TB] FAIL oneshot_resume: got %0d expected 1", dut_count(1)); end
      quiesce();
   endtask

   task automatic test_wrap();
      prescale_div = 0;
      set_mode(2, 2'b00);
      set_compare(2, 15);
      ch_enable = 4'b0100;
      for (int k = 1; k <= 16; k++) begin
         step();
         total++; if (dut_count(2) !== k % 16) begin bad++; $display("[TB] FAIL wrap_count %0d: got %0d expected %0d", k, dut_count(2), k % 16); end
         total++; if (match_flag[2] !== (k == 16)) begin bad++; $display("[TB] FAIL wrap_flag %0d: got %b expected %b", k, match_flag[2], (k == 16)); end
      end
   endtask

   task automatic test_collision();
      set_mode(0, 2'b01);
      set_compare(0, 0);
      ch_enable = 4'b0101;
      step();
      total++; if (match_flag[0] !== 1'b1) begin bad++; $display("[TB] FAIL collide_pre: got %b expected 1", match_flag[0]); end
      flag_clear = 4'b0001;
      step();
      flag_clear = '0;
      total++; if (match_flag[0] !== 1'b1) begin bad++; $display("[TB] FAIL collide_set_wins: got %b expected 1", match_flag[0]); end
      total++; if (dut_count(2) !== 2) begin bad++; $display("[TB] FAIL collide_ch2_pre: got %0d expected 2", dut_count(2)); end
      ch_clear = 4'b0100;
      #1;
      total++; if (tick !== 1'b1) begin bad++; $display("[TB] FAIL collide_tick: got %b expected 1", tick); end
      step();
      ch_clear = '0;
      total++; if (dut_count(2) !== 0) begin bad++; $display("[TB] FAIL clear_beats_tick: got %0d expected 0", dut_count(2)); end
      step();
      total++; if (dut_count(2) !== 1) begin bad++; $display("[TB] FAIL clear_then_count: got %0d expected 1", dut_count(2)); end
      quiesce();
   endtask

   task automatic test_two_channels();
      prescale_div = 1;
      set_mode(0, 2'b01);
      set_compare(0, 1);
      set_mode(3, 2'b00);
      set_compare(3, 5);
      ch_enable = 4'b0001;
      for (int c = 1; c <= 9; c++) begin
         #1;
         total++; if (tick !== (c % 2 == 0)) begin bad++; $display("[TB] FAIL two_tick clk%0d: got %b expected %b", c, tick, (c % 2 == 0)); end
         step();
         total++; if (dut_count(0) !== (c / 2) % 2) begin bad++; $display("[TB] FAIL two_ch0 clk%0d: got %0d expected %0d", c, dut_count(0), (c / 2) % 2); end
         total++; if (dut_count(3) !== 0) begin bad++; $display("[TB] FAIL two_ch3 clk%0d: got %0d expected 0", c, dut_count(3)); end
      end
      ch_enable = '0;
      #1;
      total++; if (tick !== 1'b0) begin bad++; $display("[TB] FAIL disable_tick: got %b expected 0", tick); end
      step();
      ch_enable = 4'b0001;
      prescale_div = 9;
      for (int c = 0; c < 5; c++) begin
         #1;
         total++; if (tick !== 1'b0) begin bad++; $display("[TB] FAIL reenable_tick %0d: got %b expected 0", c, tick); end
         step();
      end
      prescale_div = 2;
      #1;
      total++; if (tick !== 1'b1) begin bad++; $display("[TB] FAIL div_drop_tick: got %b expected 1", tick); end
      step();
      total++; if (tick !== 1'b0) begin bad++; $display("[TB] FAIL div_drop_after: got %b expected 0", tick); end
      quiesce();
   endtask

   task automatic test_reset_mid();
      prescale_div = 0;
      for (int c = 0; c < 3; c++) begin
         set_mode(c, 2'b00);
         set_compare(c, 0);
      end
      ch_enable = 4'b0111;
      for (int k = 0; k < 3; k++) step();
      total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_irq: got %b expected 1", irq); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      ch_enable = '0;
      #1;
      total++; if (ch_count !== '0) begin bad++; $display("[TB] FAIL mid_reset_count: got %h expected 0", ch_count); end
      total++; if (match_flag !== '0) begin bad++; $display("[TB] FAIL mid_reset_flag: got %b expected 0", match_flag); end
      total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_irq: got %b expected 0", irq); end
      total++; if (tick !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_tick: got %b expected 0", tick); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 800; n++) begin
         reset      = ($urandom_range(0, 99) < 2);
         ch_enable  = CH'($urandom);
         ch_clear   = ($urandom_range(0, 9) == 0) ? CH'($urandom) : '0;
         flag_clear = ($urandom_range(0, 5) == 0) ? CH'($urandom) : '0;
         if ($urandom_range(0, 19) == 0) prescale_div = PW'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) ch_mode = MW'($urandom);
         if ($urandom_range(0, 29) == 0) ch_compare = VW'($urandom);
         #1;
         total++; if (tick !== m_tick()) begin bad++; $display("[TB] FAIL rand_tick %0d: got %b expected %b", n, tick, m_tick()); end
         step();
         for (int c = 0; c < CH; c++) begin
            total++; if (dut_count(c) !== m_count[c]) begin bad++; $display("[TB] FAIL rand_count %0d ch%0d: got %0d expected %0d", n, c, dut_count(c), m_count[c]); end
            total++; if (match_flag[c] !== m_flag[c]) begin bad++; $display("[TB] FAIL rand_flag %0d ch%0d: got %b expected %b", n, c, match_flag[c], m_flag[c]); end
         end
         total++; if (irq !== m_irq()) begin bad++; $display("[TB] FAIL rand_irq %0d: got %b expected %b", n, irq, m_irq()); end
      end
      reset = 1'b0;
      quiesce();
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      m_pre        = 0;
      for (int c = 0; c < CH; c++) begin
         m_count[c] = 0;
         m_done[c]  = 1'b0;
         m_flag[c]  = 1'b0;
      end
      reset        = 1'b0;
      prescale_div = '0;
      ch_enable    = '0;
      ch_clear     = '0;
      ch_mode      = '0;
      ch_compare   = '0;
      flag_clear   = '0;

      test_reset();
      test_periodic();
      test_oneshot();
      test_wrap();
      test_collision();
      test_two_channels();
      test_reset_mid();
      test_random();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
